pong_round_ctrl: RTL and testbench

//  Game-sequencing FSM for pong. Consumes the per-cycle miss1/miss2 flags from the

---
 rtl/pong_round_ctrl_if.sv | 27 ++
 rtl/pong_round_ctrl.sv | 124 ++++++++++++
 tb/tb_pong_round_ctrl.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/pong_round_ctrl_if.sv
// Bundles the round controller's inputs (from the edge detector) and outputs (to ball/HUD logic).
interface pong_round_ctrl_if #(
  parameter int unsigned SCORE_W = 4
);
  logic               start;
  logic               frame_tick;
  logic               miss1;
  logic               miss2;
  logic               ball_load;
  logic               ball_run;
  logic               serve_dir;
  logic [SCORE_W-1:0] score1;
  logic [SCORE_W-1:0] score2;
  logic               game_over;
  logic               winner;
  logic [2:0]         state;

  modport master (
    output start, frame_tick, miss1, miss2,
    input  ball_load, ball_run, serve_dir, score1, score2, game_over, winner, state
  );

  modport slave (
    input  start, frame_tick, miss1, miss2,
    output ball_load, ball_run, serve_dir, score1, score2, game_over, winner, state
  );
endinterface

// File: rtl/pong_round_ctrl.sv
// Pong game sequencer: serve / play / point / game-over, with both scores kept here.
module pong_round_ctrl #(
  parameter int unsigned SCORE_W      = 4,
  parameter int unsigned WIN_SCORE    = 7,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned POINT_FRAMES = 30
) (
  input logic CLOCK_50,
  input logic Reset,
  pong_round_ctrl_if.slave bus
);

  localparam int unsigned MaxFrames = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
  localparam int unsigned TimerW    = (MaxFrames > 1) ? $clog2(MaxFrames) : 1;

  localparam logic [TimerW-1:0]  ServeLoad = TimerW'(SERVE_FRAMES - 1);
  localparam logic [TimerW-1:0]  PointLoad = TimerW'(POINT_FRAMES - 1);
  localparam logic [SCORE_W-1:0] WinVal    = SCORE_W'(WIN_SCORE);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StServe = 3'd1,
    StPlay  = 3'd2,
    StPoint = 3'd3,
    StOver  = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [TimerW-1:0]  timer_q, timer_d;
  logic [SCORE_W-1:0] score1_q, score1_d;
  logic [SCORE_W-1:0] score2_q, score2_d;
  logic               dir_q, dir_d;
  logic               winner_q, winner_d;

  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      state_q  <= StIdle;
      timer_q  <= '0;
      score1_q <= '0;
      score2_q <= '0;
      dir_q    <= 1'b0;
      winner_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      score1_q <= score1_d;
      score2_q <= score2_d;
      dir_q    <= dir_d;
      winner_q <= winner_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    score1_d = score1_q;
    score2_d = score2_q;
    dir_d    = dir_q;
    winner_d = winner_q;

    case (state_q)
      StIdle, StOver: begin
        if (bus.start) begin
          state_d  = StServe;
          timer_d  = ServeLoad;
          score1_d = '0;
          score2_d = '0;
        end
      end
      StServe: begin
        if (bus.frame_tick) begin
          if (timer_q == '0) begin
            state_d = StPlay;
          end else begin
            timer_d = timer_q - 1'b1;
          end
        end
      end
      StPlay: begin
        // Leaving PLAY on the first miss cycle is what makes a held miss score once.
        if (bus.miss1) begin
          score2_d = (score2_q == WinVal) ? score2_q : score2_q + 1'b1;
          dir_d    = 1'b0;
          state_d  = StPoint;
          timer_d  = PointLoad;
        end else if (bus.miss2) begin
          score1_d = (score1_q == WinVal) ? score1_q : score1_q + 1'b1;
          dir_d    = 1'b1;
          state_d  = StPoint;
          timer_d  = PointLoad;
        end
      end
      StPoint: begin
        if (bus.frame_tick) begin
          if (timer_q == '0) begin
            if (score1_q == WinVal) begin
              state_d  = StOver;
              winner_d = 1'b0;
            end else if (score2_q == WinVal) begin
              state_d  = StOver;
              winner_d = 1'b1;
            end else begin
              state_d = StServe;
              timer_d = ServeLoad;
            end
          end else begin
            timer_d = timer_q - 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.ball_load = (state_q != StPlay) && (state_q != StPoint);
  assign bus.ball_run  = (state_q == StPlay);
  assign bus.game_over = (state_q == StOver);
  assign bus.serve_dir = dir_q;
  assign bus.score1    = score1_q;
  assign bus.score2    = score2_q;
  assign bus.winner    = winner_q;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_pong_round_ctrl.sv
// Directed scenarios followed by random play, all checked against a phase/tick-count model.
module tb_pong_round_ctrl;

  localparam int unsigned ScoreW = 4;
  localparam int unsigned Win    = 3;
  localparam int unsigned ServeN = 3;
  localparam int unsigned PointN = 2;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  // Reference model: game phase number plus ticks seen in the current timed phase.
  int m_phase;
  int m_ticks;
  int m_s1;
  int m_s2;
  int m_dir;
  int m_win;

  pong_round_ctrl_if #(.SCORE_W(ScoreW)) bus ();

  pong_round_ctrl #(
    .SCORE_W     (ScoreW),
    .WIN_SCORE   (Win),
    .SERVE_FRAMES(ServeN),
    .POINT_FRAMES(PointN)
  ) dut (
    .CLOCK_50(clk),
    .Reset   (rst),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit st, input bit tk, input bit m1, input bit m2);
    if (r) begin
      m_phase = 0; m_ticks = 0; m_s1 = 0; m_s2 = 0; m_dir = 0; m_win = 0;
      return;
    end
    case (m_phase)
      0, 4: if (st) begin m_phase = 1; m_ticks = 0; m_s1 = 0; m_s2 = 0; end
      1: if (tk) begin
        m_ticks++;
        if (m_ticks == ServeN) m_phase = 2;
      end
      2: if (m1) begin
        m_s2 = (m_s2 + 1 > Win) ? Win : m_s2 + 1; m_dir = 0; m_phase = 3; m_ticks = 0;
      end else if (m2) begin
        m_s1 = (m_s1 + 1 > Win) ? Win : m_s1 + 1; m_dir = 1; m_phase = 3; m_ticks = 0;
      end
      3: if (tk) begin
        m_ticks++;
        if (m_ticks == PointN) begin
          if (m_s1 == Win) begin m_phase = 4; m_win = 0; end
          else if (m_s2 == Win) begin m_phase = 4; m_win = 1; end
          else begin m_phase = 1; m_ticks = 0; end
        end
      end
      default: m_phase = 0;
    endcase
  endtask

  task automatic compare_all();
    check("state", 32'(bus.state), 32'(m_phase));
    check("ball_load", 32'(bus.ball_load), 32'(m_phase == 0 || m_phase == 1 || m_phase == 4));
    check("ball_run", 32'(bus.ball_run), 32'(m_phase == 2));
    check("game_over", 32'(bus.game_over), 32'(m_phase == 4));
    check("score1", 32'(bus.score1), 32'(m_s1));
    check("score2", 32'(bus.score2), 32'(m_s2));
    check("serve_dir", 32'(bus.serve_dir), 32'(m_dir));
    check("winner", 32'(bus.winner), 32'(m_win));
  endtask

  task automatic step(input bit r, input bit st, input bit tk, input bit m1, input bit m2);
    rst            = r;
    bus.start      = st;
    bus.frame_tick = tk;
    bus.miss1      = m1;
    bus.miss2      = m2;
    @(posedge clk);
    model_step(r, st, tk, m1, m2);
    #1;
    compare_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      step(0, 0, 0, 0, 0);
      step(0, 0, 1, 0, 0);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    m_phase = 0; m_ticks = 0; m_s1 = 0; m_s2 = 0; m_dir = 0; m_win = 0;
    rst = 1'b1;
    bus.start = 1'b0; bus.frame_tick = 1'b0; bus.miss1 = 1'b0; bus.miss2 = 1'b0;

    // 1. reset
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    check("reset_state", 32'(bus.state), 32'd0);
    check("reset_load", 32'(bus.ball_load), 32'd1);

    // 2. serve lasts exactly three ticks
    step(0, 1, 0, 0, 0);
    ticks(2);
    check("serve_hold", 32'(bus.state), 32'd1);
    ticks(1);
    check("play_entry", 32'(bus.ball_run), 32'd1);

    // 3. held miss1 scores once
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0);
    check("held_miss_score2", 32'(bus.score2), 32'd1);
    ticks(2);
    check("point_to_serve", 32'(bus.state), 32'd1);

    // 4. simultaneous misses and tick
    ticks(3);
    step(0, 0, 1, 1, 1);
    check("both_miss_s2", 32'(bus.score2), 32'd2);
    check("both_miss_s1", 32'(bus.score1), 32'd0);
    ticks(2);

    // 5. player 2 misses three rounds; player 1 wins
    for (int r = 0; r < 3; r++) begin
      ticks(3);
      step(0, 0, 0, 0, 1);
      ticks(2);
    end
    check("over_state", 32'(bus.state), 32'd4);
    check("over_winner", 32'(bus.winner), 32'd0);
    step(0, 1, 0, 0, 0);
    check("restart_s1", 32'(bus.score1), 32'd0);

    // 6. reset mid-SERVE (timer=1) and mid-POINT
    ticks(1);
    step(1, 0, 0, 0, 0);
    check("rst_serve_run", 32'(bus.ball_run), 32'd0);
    step(0, 1, 0, 0, 0);
    ticks(3);
    step(0, 0, 0, 1, 0);
    ticks(1);
    step(1, 0, 0, 0, 0);
    check("rst_point_s2", 32'(bus.score2), 32'd0);
    step(0, 1, 0, 0, 0);
    ticks(3);
    check("rst_timer_clear", 32'(bus.state), 32'd2);

    // random play
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(199) == 0), ($urandom_range(5) == 0), ($urandom_range(2) == 0),
           ($urandom_range(9) == 0), ($urandom_range(7) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
